// File: rtl/wm_panel_ctrl.sv
// Front-panel conditioning and door-lock interlock ahead of the wash sequencer; WM_CHILD_LOCK_EN adds a child_lock panel lockout.
// Latency: raw input to debounced level is 2+DEBOUNCE_CYCLES edges. Mains loss sets power_cut 3 edges later. No backpressure.
module wm_panel_ctrl #(
  parameter int DEBOUNCE_CYCLES     = 4,
  parameter int LOCK_SETTLE_CYCLES  = 3,
  parameter int UNLOCK_DELAY_CYCLES = 5,
  parameter int PWR_HOLD_CYCLES     = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_start_raw,
  input  logic       btn_pause_raw,
  input  logic       door_sw_raw,
  input  logic       mains_ok_raw,
  input  logic [2:0] machine_state,
`ifdef WM_CHILD_LOCK_EN
  input  logic       child_lock,
`endif
  output logic       start,
  output logic       pause,
  output logic       door_open,
  output logic       power_cut,
  output logic       door_lock,
  output logic       door_fault
);

  localparam int DBW  = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int PHW  = $clog2(PWR_HOLD_CYCLES + 1);
  localparam int TMAX = (LOCK_SETTLE_CYCLES > UNLOCK_DELAY_CYCLES) ? LOCK_SETTLE_CYCLES : UNLOCK_DELAY_CYCLES;
  localparam int TW   = $clog2(TMAX + 1);
  localparam logic [DBW-1:0] DB_LAST     = DBW'(DEBOUNCE_CYCLES - 1);
  localparam logic [PHW-1:0] PH_LAST     = PHW'(PWR_HOLD_CYCLES - 1);
  localparam logic [TW-1:0]  SETTLE_LAST = TW'(LOCK_SETTLE_CYCLES - 1);
  localparam logic [TW-1:0]  UNLOCK_LAST = TW'(UNLOCK_DELAY_CYCLES - 1);
  localparam logic [2:0]     ST_IDLE     = 3'd0;
  localparam logic [2:0]     ST_DONE     = 3'd6;
  // Bit order {mains, door, pause, start}; door idles open and mains idles bad.
  localparam logic [3:0]     SYNC_RST    = 4'b0100;

  typedef enum logic [1:0] {UNLOCKED, LOCKING, LOCKED, UNLOCKING} lock_state_t;

  logic [3:0]     sync1, sync2;
  logic [2:0]     deb, deb_nxt;
  logic [DBW-1:0] dcnt     [3];
  logic [DBW-1:0] dcnt_nxt [3];
  logic [PHW-1:0] pcnt;
  logic           door_now, start_press, pause_press, panel_en;
  lock_state_t    state, state_nxt;
  logic [TW-1:0]  tcnt, tcnt_nxt;
  logic [1:0]     idle_cnt, idle_nxt;
  logic           start_nxt, pause_nxt, fault_set;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1 <= SYNC_RST;
      sync2 <= SYNC_RST;
    end else begin
      sync1 <= {mains_ok_raw, door_sw_raw, btn_pause_raw, btn_start_raw};
      sync2 <= sync1;
    end
  end

  always_comb begin
    deb_nxt = deb;
    for (int i = 0; i < 3; i++) begin
      dcnt_nxt[i] = '0;
      if (sync2[i] != deb[i]) begin
        if (dcnt[i] >= DB_LAST) deb_nxt[i] = sync2[i];
        else dcnt_nxt[i] = dcnt[i] + DBW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      deb <= 3'b100;
      for (int i = 0; i < 3; i++) dcnt[i] <= '0;
    end else begin
      deb <= deb_nxt;
      for (int i = 0; i < 3; i++) dcnt[i] <= dcnt_nxt[i];
    end
  end

  // The interlock acts on the debounced value being loaded this edge, so lock and door_open move together.
  assign door_now  = deb_nxt[2];
  assign door_open = deb[2];

`ifdef WM_CHILD_LOCK_EN
  assign panel_en = ~child_lock;
`else
  assign panel_en = 1'b1;
`endif

  assign start_press = deb_nxt[0] & ~deb[0] & panel_en & ~power_cut;
  assign pause_press = deb_nxt[1] & ~deb[1] & panel_en & ~power_cut & ~start_press;

  always_ff @(posedge clk) begin
    if (reset) begin
      power_cut <= 1'b1;
      pcnt      <= '0;
    end else if (!sync2[3]) begin
      power_cut <= 1'b1;
      pcnt      <= '0;
    end else if (power_cut) begin
      if (pcnt >= PH_LAST) begin
        power_cut <= 1'b0;
        pcnt      <= '0;
      end else begin
        pcnt <= pcnt + PHW'(1);
      end
    end
  end

  always_comb begin
    state_nxt = state;
    tcnt_nxt  = tcnt;
    idle_nxt  = idle_cnt;
    start_nxt = 1'b0;
    fault_set = 1'b0;
    pause_nxt = pause;
    case (state)
      UNLOCKED: begin
        if (start_press && machine_state == ST_IDLE && !door_now) begin
          state_nxt = LOCKING;
          tcnt_nxt  = '0;
        end
      end
      LOCKING: begin
        if (door_now || power_cut) begin
          state_nxt = UNLOCKED;
          tcnt_nxt  = '0;
        end else if (tcnt >= SETTLE_LAST) begin
          state_nxt = LOCKED;
          tcnt_nxt  = '0;
          idle_nxt  = '0;
          start_nxt = 1'b1;
        end else begin
          tcnt_nxt = tcnt + TW'(1);
        end
      end
      LOCKED: begin
        if (!power_cut) begin
          if (door_now) begin
            state_nxt = UNLOCKED;
            fault_set = 1'b1;
          end else if (machine_state == ST_DONE) begin
            state_nxt = UNLOCKING;
            tcnt_nxt  = '0;
          end else if (machine_state == ST_IDLE && !pause) begin
            // Sequencer dropped back to IDLE without finishing: release after two quiet cycles.
            if (idle_cnt >= 2'd1) begin
              state_nxt = UNLOCKING;
              tcnt_nxt  = '0;
            end else begin
              idle_nxt = idle_cnt + 2'd1;
            end
          end else begin
            idle_nxt = '0;
          end
        end
      end
      UNLOCKING: begin
        if (!power_cut) begin
          if (tcnt >= UNLOCK_LAST) begin
            state_nxt = UNLOCKED;
            tcnt_nxt  = '0;
          end else begin
            tcnt_nxt = tcnt + TW'(1);
          end
        end
      end
      default: state_nxt = UNLOCKED;
    endcase

    if (machine_state == ST_IDLE || machine_state == ST_DONE || door_now || state != LOCKED)
      pause_nxt = 1'b0;
    else if (pause_press)
      pause_nxt = ~pause;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= UNLOCKED;
      tcnt       <= '0;
      idle_cnt   <= '0;
      start      <= 1'b0;
      pause      <= 1'b0;
      door_lock  <= 1'b0;
      door_fault <= 1'b0;
    end else begin
      state      <= state_nxt;
      tcnt       <= tcnt_nxt;
      idle_cnt   <= idle_nxt;
      start      <= start_nxt;
      pause      <= pause_nxt;
      door_lock  <= (state_nxt != UNLOCKED);
      door_fault <= door_fault | fault_set;
    end
  end

endmodule

// File: tb/tb_wm_panel_ctrl.sv
// Bench for wm_panel_ctrl: constant vector table, hand-built corner sequences, then random stimulus against a rule-level model.
module tb_wm_panel_ctrl;
  localparam int DEB = 4;
  localparam int SET = 3;
  localparam int UNL = 5;
  localparam int PWR = 8;
  localparam int M_OPEN = 0;
  localparam int M_ARM  = 1;
  localparam int M_RUN  = 2;
  localparam int M_REL  = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic bs = 1'b0, bp = 1'b0, dr = 1'b0, mo = 1'b1, child = 1'b0;
  logic [2:0] ms = 3'd0;
  logic start, pause, door_open, power_cut, door_lock, door_fault;

  int checks = 0;
  int errors = 0;
  int start_seen = 0;

  wm_panel_ctrl #(
    .DEBOUNCE_CYCLES(DEB), .LOCK_SETTLE_CYCLES(SET),
    .UNLOCK_DELAY_CYCLES(UNL), .PWR_HOLD_CYCLES(PWR)
  ) dut (
    .clk(clk), .reset(rst),
    .btn_start_raw(bs), .btn_pause_raw(bp), .door_sw_raw(dr), .mains_ok_raw(mo),
    .machine_state(ms),
`ifdef WM_CHILD_LOCK_EN
    .child_lock(child),
`endif
    .start(start), .pause(pause), .door_open(door_open), .power_cut(power_cut),
    .door_lock(door_lock), .door_fault(door_fault)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  logic [3:0]     rawq [$];
  logic [DEB-1:0] hist [3];
  logic [2:0]     m_deb;
  logic           m_pc, m_start, m_pause, m_lock, m_fault;
  int             m_good, m_mode, m_prog, m_idle;

  task automatic model_reset();
    rawq = {};
    rawq.push_back(4'b0100);
    rawq.push_back(4'b0100);
    hist[0] = '0; hist[1] = '0; hist[2] = '1;
    m_deb = 3'b100; m_pc = 1'b1; m_good = 0;
    m_mode = M_OPEN; m_prog = 0; m_idle = 0;
    m_start = 1'b0; m_pause = 1'b0; m_lock = 1'b0; m_fault = 1'b0;
  endtask

  task automatic model_step();
    logic [3:0] samp;
    logic [2:0] dn, rise;
    logic door_now, pc_old, pause_old, sp, pp;
    int mode_old;
    if (rst) begin
      model_reset();
      return;
    end
    samp = rawq.pop_front();
    rawq.push_back({mo, dr, bp, bs});
    dn = m_deb;
    for (int b = 0; b < 3; b++) begin
      hist[b] = {hist[b][DEB-2:0], samp[b]};
      if (hist[b] == {DEB{~m_deb[b]}}) dn[b] = ~m_deb[b];
    end
    rise = dn & ~m_deb;
    m_deb = dn;
    door_now = dn[2];
    pc_old = m_pc;
    if (!samp[3]) begin
      m_pc = 1'b1;
      m_good = 0;
    end else begin
      m_good++;
      if (m_good >= PWR) m_pc = 1'b0;
    end
    sp = rise[0] && !pc_old && !child;
    pp = rise[1] && !pc_old && !child && !sp;
    pause_old = m_pause;
    mode_old = m_mode;
    m_start = 1'b0;
    if (ms == 3'd0 || ms == 3'd6 || door_now || mode_old != M_RUN) m_pause = 1'b0;
    else if (pp) m_pause = !m_pause;
    case (mode_old)
      M_OPEN: if (sp && ms == 3'd0 && !door_now) begin m_mode = M_ARM; m_prog = 0; end
      M_ARM: begin
        if (door_now || pc_old) m_mode = M_OPEN;
        else begin
          m_prog++;
          if (m_prog == SET) begin m_mode = M_RUN; m_start = 1'b1; m_idle = 0; end
        end
      end
      M_RUN: if (!pc_old) begin
        if (door_now) begin m_mode = M_OPEN; m_fault = 1'b1; end
        else if (ms == 3'd6) begin m_mode = M_REL; m_prog = 0; end
        else begin
          if (ms == 3'd0 && !pause_old) m_idle++;
          else m_idle = 0;
          if (m_idle == 2) begin m_mode = M_REL; m_prog = 0; end
        end
      end
      default: if (!pc_old) begin
        m_prog++;
        if (m_prog == UNL) m_mode = M_OPEN;
      end
    endcase
    m_lock = (m_mode != M_OPEN);
  endtask

  always @(posedge clk) model_step();

  function automatic logic [5:0] model_vec();
    return {m_start, m_pause, m_deb[2], m_pc, m_lock, m_fault};
  endfunction

  // ---------------- helpers ----------------
  function automatic logic [5:0] outv();
    return {start, pause, door_open, power_cut, door_lock, door_fault};
  endfunction

  task automatic chk(input string name, input int act, input int want);
    checks++;
    if (act != want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, want);
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      if (start) start_seen++;
    end
  endtask

  task automatic powerup();
    rst = 1'b1; bs = 0; bp = 0; dr = 0; mo = 1; ms = 3'd0; child = 0;
    tick(1);
    rst = 1'b0;
    tick(10);
  endtask

  task automatic reset_and_lock();
    powerup();
    bs = 1; tick(9);
    ms = 3'd2; tick(1);
    bs = 0; tick(6);
    chk("lock_ready", int'(door_lock), 1);
  endtask

  typedef struct {
    logic rst, bs, bp, dr, mo;
    logic [2:0] ms;
    int n;
    logic [5:0] want;  // {start, pause, door_open, power_cut, door_lock, door_fault}
  } vec_t;
  vec_t tbl [$];

  task automatic add(input logic r, input logic s, input logic p, input logic d, input logic m,
                     input logic [2:0] st, input int n, input logic [5:0] w);
    vec_t v;
    v.rst = r; v.bs = s; v.bp = p; v.dr = d; v.mo = m; v.ms = st; v.n = n; v.want = w;
    tbl.push_back(v);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    // Power-up, start handshake, pause toggling, IDLE fallback release.
    add(1, 0, 0, 0, 1, 3'd0, 1, 6'b001100);
    add(0, 0, 0, 0, 1, 3'd0, 5, 6'b001100);
    add(0, 0, 0, 0, 1, 3'd0, 4, 6'b000100);
    add(0, 0, 0, 0, 1, 3'd0, 1, 6'b000000);
    add(0, 1, 0, 0, 1, 3'd0, 5, 6'b000000);
    add(0, 1, 0, 0, 1, 3'd0, 3, 6'b000010);
    add(0, 1, 0, 0, 1, 3'd0, 1, 6'b100010);
    add(0, 1, 0, 0, 1, 3'd2, 1, 6'b000010);
    add(0, 0, 1, 0, 1, 3'd2, 5, 6'b000010);
    add(0, 0, 1, 0, 1, 3'd2, 3, 6'b010010);
    add(0, 0, 0, 0, 1, 3'd2, 6, 6'b010010);
    add(0, 0, 1, 0, 1, 3'd2, 5, 6'b010010);
    add(0, 0, 1, 0, 1, 3'd2, 1, 6'b000010);
    add(0, 0, 0, 0, 1, 3'd2, 6, 6'b000010);
    add(0, 0, 1, 0, 1, 3'd0, 6, 6'b000010);
    add(0, 0, 1, 0, 1, 3'd0, 1, 6'b000000);
    add(0, 0, 0, 0, 1, 3'd0, 6, 6'b000000);

    foreach (tbl[r]) begin
      rst = tbl[r].rst; bs = tbl[r].bs; bp = tbl[r].bp;
      dr = tbl[r].dr; mo = tbl[r].mo; ms = tbl[r].ms;
      for (int k = 0; k < tbl[r].n; k++) begin
        tick(1);
        chk($sformatf("vec%0d.%0d", r, k), int'(outv()), int'(tbl[r].want));
      end
    end

    // Short start press is filtered out.
    powerup();
    start_seen = 0;
    bs = 1; tick(2);
    bs = 0; tick(10);
    chk("short_press_lock", int'(door_lock), 0);
    chk("short_press_start", start_seen, 0);

    // One-cycle mains dip while locked.
    reset_and_lock();
    mo = 0; tick(1);
    mo = 1; tick(2);
    chk("pc_set", int'(power_cut), 1);
    chk("pc_set_lock", int'(door_lock), 1);
    for (int e = 4; e <= 10; e++) begin
      tick(1);
      chk($sformatf("pc_hold%0d", e), int'({power_cut, door_lock}), 3);
    end
    tick(3);
    chk("pc_clear", int'({power_cut, door_lock}), 1);

    // Door opened while locked.
    reset_and_lock();
    dr = 1; tick(5);
    chk("tamper_pre", int'({door_lock, door_fault}), 2);
    tick(1);
    chk("tamper_hit", int'({door_open, door_lock, door_fault}), 3'b101);
    dr = 0; tick(8);
    chk("fault_sticky", int'({door_open, door_fault}), 1);
    rst = 1; tick(1);
    chk("fault_reset", int'(door_fault), 0);
    rst = 0;

    // Normal end of cycle.
    reset_and_lock();
    ms = 3'd6; tick(5);
    chk("done_hold", int'(door_lock), 1);
    tick(1);
    chk("done_release", int'(door_lock), 0);

    // Reset in the middle of a paused cycle.
    reset_and_lock();
    bp = 1; tick(6);
    chk("mid_pause", int'(pause), 1);
    rst = 1; tick(1);
    chk("mid_reset", int'(outv()), 6'b001100);
    rst = 0; bp = 0;

`ifdef WM_CHILD_LOCK_EN
    powerup();
    child = 1; bs = 1; start_seen = 0;
    tick(10);
    chk("child_start", start_seen, 0);
    chk("child_lock", int'(door_lock), 0);
    child = 0; tick(10);
    chk("child_held", int'(door_lock), 0);
    bs = 0; tick(6);
`endif

    // Random stimulus against the model.
    rst = 1; bs = 0; bp = 0; dr = 0; mo = 1; ms = 3'd0; child = 0;
    tick(1);
    rst = 0;
    for (int c = 0; c < 4000; c++) begin
      rst = ($urandom_range(0, 999) == 0);
      if ($urandom_range(0, 5) == 0) bs = ~bs;
      if ($urandom_range(0, 5) == 0) bp = ~bp;
      if (dr) begin if ($urandom_range(0, 7) == 0) dr = 0; end
      else if ($urandom_range(0, 149) == 0) dr = 1;
      if (mo) begin if ($urandom_range(0, 199) == 0) mo = 0; end
      else if ($urandom_range(0, 2) == 0) mo = 1;
      if ($urandom_range(0, 24) == 0) begin
        case ($urandom_range(0, 3))
          0: ms = 3'd0;
          1: ms = 3'd2;
          2: ms = 3'd3;
          default: ms = 3'd6;
        endcase
      end
`ifdef WM_CHILD_LOCK_EN
      if ($urandom_range(0, 29) == 0) child = ~child;
`endif
      tick(1);
      chk($sformatf("rand%0d", c), int'(outv()), int'(model_vec()));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
